div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
Sequencing controller for the iterative 32-bit divider core in the EX stage. It accepts RV32M divide/remainder requests through a valid/ready handshake and resolves divide-by-zero and signed overflow on a one-cycle fast path. All other requests go to the divider: the controller holds its enable high and its operands stable for the whole run, and owns the shared ALU adder for the duration. It presents the result to writeback through a valid/ready handshake. A watchdog flags a divider that never finishes.

Parameters:
DIV_LAT, 67, enabled cycles from divider enable rising to div_finish_i; used only for the watchdog.
TIMEOUT, 80, RUN cycles without div_finish_i before the watchdog fires; must be greater than DIV_LAT.
FAST_PATH_EN, 1, when 1, divide-by-zero and signed-overflow requests bypass the divider.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when req_valid_i && req_ready_o
req_funct3_i  in  3  DIV=100, DIVU=101, REM=110, REMU=111
req_a_i  in  32  dividend
req_b_i  in  32  divisor
req_rd_i  in  5  destination register tag
flush_i  in  1  pipeline kill
resp_valid_o  out  1  result valid
resp_ready_i  in  1  writeback accepts the result
resp_data_o  out  32  result
resp_rd_o  out  5  destination tag of the result
div_en_o  out  1  divider enable; the divider clears itself when this is low
div_funct3_o  out  3  captured funct3 driven to the divider
div_a_o  out  32  captured dividend driven to the divider
div_b_o  out  32  captured divisor driven to the divider
div_finish_i  in  1  divider done; div_result_i is valid in the same cycle
div_result_i  in  32  divider result
div_sub_i  in  1  divider requests a subtract step
alu_div_sel_o  out  1  ALU operand mux selects the divider
alu_sub_o  out  1  ALU subtract control while the divider owns the ALU
busy_o  out  1  state != IDLE
err_o  out  1  sticky watchdog error flag

Behaviour:
- Reset: rst low at a clk edge forces the following, regardless of state or any in-flight operation:
  - state IDLE; req_ready_o becomes 1 after reset is released.
  - resp_valid_o, div_en_o, alu_div_sel_o, alu_sub_o, busy_o and err_o are 0.
  - resp_data_o, resp_rd_o, the captured operand registers and the cycle counter are 0.
- States are IDLE, FAST, RUN and DONE.
- IDLE:
  - req_ready_o = !flush_i.
  - On accept, capture funct3, a, b and rd.
  - Go to FAST if FAST_PATH_EN and the request is a fast-path case; otherwise go to RUN.
- Fast-path cases:
  - b == 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return a.
  - Signed overflow (a == 0x80000000, b == 0xFFFFFFFF) with DIV returns 0x80000000; with REM returns 0.
  - Unsigned operations never overflow.
- FAST: one cycle. Load the result register, then go to DONE. div_en_o stays 0.
- RUN:
  - div_en_o = 1 and alu_div_sel_o = 1.
  - alu_sub_o = div_sub_i.
  - div_a_o, div_b_o and div_funct3_o come from the captured registers and are stable for the whole run.
  - The cycle counter increments each RUN cycle.
  - On div_finish_i: capture div_result_i and go to DONE.
  - If the counter reaches TIMEOUT without div_finish_i: set err_o, load result 0 and go to DONE.
- DONE:
  - resp_valid_o = 1; resp_data_o and resp_rd_o are held stable.
  - On resp_ready_i, go to IDLE.
  - div_en_o = 0, so the divider clears.
- Latency from the accept edge:
  - Fast path: resp_valid_o rises 2 cycles later.
  - Divider path: RUN occupies DIV_LAT cycles, and resp_valid_o rises DIV_LAT+1 cycles later (68 with the default).
- Throughput: requests are accepted only in IDLE. There is at least one idle cycle between the resp handshake and the next accept.
- Flush:
  - flush_i in any state goes to IDLE at the next edge.
  - div_en_o, resp_valid_o and alu_div_sel_o drop that edge; err_o is unchanged.
  - Flush beats a same-cycle resp handshake: the result is discarded and writeback must ignore it.
  - Flush beats a same-cycle request: req_ready_o is 0, so nothing is accepted.
- Simultaneous div_finish_i and flush_i: flush wins; the result is not captured.
- Operands reach the divider raw. The divider performs sign handling itself, driven by div_funct3_o.
- The cycle counter is 7 bits wide, is cleared on entry to RUN, and saturates.

Test Plan:
1. DIVU a=100, b=7, resp_ready_i held 1 -> RUN lasts 67 cycles with div_en_o=1 throughout; resp_data_o=14 at cycle 68; then IDLE.
2. DIV a=0xFFFFFF9C (-100), b=7, then REM with the same operands -> results 0xFFFFFFF2 (-14) and 0xFFFFFFFE (-2); resp_rd_o matches each request's rd.
3. DIV/DIVU/REM/REMU with b=0, a=0x1234 -> fast path, resp_valid_o 2 cycles after accept; results 0xFFFFFFFF, 0xFFFFFFFF, 0x1234, 0x1234; div_en_o never asserts.
4. DIV and REM with a=0x80000000, b=0xFFFFFFFF -> fast path; results 0x80000000 and 0.
5. Divider request with flush_i pulsed at RUN cycle 30 -> div_en_o low and IDLE next cycle with no resp_valid_o. A new DIVU 9/3 then returns 3 after the full latency.
6. div_finish_i tied 0 -> err_o=1 and resp_data_o=0 after TIMEOUT=80 RUN cycles. resp_ready_i held 0 for 5 cycles keeps resp_valid_o and data stable and req_ready_o=0. Reset with rst=0 then clears err_o.

Source files
------------

// File: rtl/div_ctrl.sv
// Sequencing controller for the iterative RV32M divider: request/response handshakes,
// a one-cycle fast path for divide-by-zero and signed overflow, and a run watchdog.
`timescale 1ns/1ps
module div_ctrl #(
  parameter int unsigned DIV_LAT      = 67,
  parameter int unsigned TIMEOUT      = 80,
  parameter bit          FAST_PATH_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic [4:0]  resp_rd_o,
  output logic        div_en_o,
  output logic [2:0]  div_funct3_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  input  logic        div_finish_i,
  input  logic [31:0] div_result_i,
  input  logic        div_sub_i,
  output logic        alu_div_sel_o,
  output logic        alu_sub_o,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [1:0] {StIdle, StFast, StRun, StDone} state_e;

  // The watchdog must never fire before a healthy divider can finish.
  localparam int unsigned TimeoutLim = (TIMEOUT > DIV_LAT) ? TIMEOUT : DIV_LAT + 1;
  localparam logic [6:0]  CntLast    = 7'(TimeoutLim - 1);

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        b_zero, ovf, is_fast;
  logic [31:0] fast_res;

  // Overflow only exists for the signed ops (funct3[0] == 0).
  assign b_zero  = (req_b_i == '0);
  assign ovf     = ~req_funct3_i[0] & (req_a_i == 32'h8000_0000) & (req_b_i == '1);
  assign is_fast = FAST_PATH_EN & (b_zero | ovf);

  // funct3[1] distinguishes REM/REMU from DIV/DIVU.
  always_comb begin
    if (b_q == '0) begin
      fast_res = funct3_q[1] ? a_q : '1;
    end else begin
      fast_res = funct3_q[1] ? '0 : 32'h8000_0000;
    end
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_d     = rd_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            funct3_d = req_funct3_i;
            a_d      = req_a_i;
            b_d      = req_b_i;
            rd_d     = req_rd_i;
            cnt_d    = '0;
            state_d  = is_fast ? StFast : StRun;
          end
        end
        StFast: begin
          result_d = fast_res;
          state_d  = StDone;
        end
        StRun: begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 7'd1;
          if (div_finish_i) begin
            result_d = div_result_i;
            state_d  = StDone;
          end else if (cnt_q >= CntLast) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = StDone;
          end
        end
        StDone: begin
          if (resp_ready_i) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      funct3_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign req_ready_o   = (state_q == StIdle) & ~flush_i;
  assign resp_valid_o  = (state_q == StDone);
  assign resp_data_o   = result_q;
  assign resp_rd_o     = rd_q;
  assign div_en_o      = (state_q == StRun);
  assign div_funct3_o  = funct3_q;
  assign div_a_o       = a_q;
  assign div_b_o       = b_q;
  assign alu_div_sel_o = (state_q == StRun);
  assign alu_sub_o     = (state_q == StRun) & div_sub_i;
  assign busy_o        = (state_q != StIdle);
  assign err_o         = err_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural fixed-latency divider model.
`timescale 1ns/1ps
module tb_div_ctrl;

  localparam int unsigned DivLat = 67;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i = '0;
  logic [31:0] req_a_i = '0;
  logic [31:0] req_b_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        flush_i = 1'b0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_rd_o;
  logic        div_en_o;
  logic [2:0]  div_funct3_o;
  logic [31:0] div_a_o;
  logic [31:0] div_b_o;
  logic        div_finish_i;
  logic [31:0] div_result_i;
  logic        div_sub_i;
  logic        alu_div_sel_o;
  logic        alu_sub_o;
  logic        busy_o;
  logic        err_o;

  int n_chk = 0;
  int n_err = 0;

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_funct3_i (req_funct3_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_rd_i     (req_rd_i),
    .flush_i      (flush_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_rd_o    (resp_rd_o),
    .div_en_o     (div_en_o),
    .div_funct3_o (div_funct3_o),
    .div_a_o      (div_a_o),
    .div_b_o      (div_b_o),
    .div_finish_i (div_finish_i),
    .div_result_i (div_result_i),
    .div_sub_i    (div_sub_i),
    .alu_div_sel_o(alu_div_sel_o),
    .alu_sub_o    (alu_sub_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Divider model: finishes in its DivLat-th enabled cycle, clears when disabled.
  int   en_cnt = 0;
  logic finish_en = 1'b1;
  always @(posedge clk) en_cnt <= div_en_o ? en_cnt + 1 : 0;
  assign div_finish_i = finish_en & div_en_o & (en_cnt == DivLat - 1);
  assign div_sub_i    = en_cnt[0];

  function automatic logic [31:0] model_div(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    if (b == '0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 32'hDEAD_BEEF;
    case (f3[1:0])
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  always_comb div_result_i = model_div(div_funct3_o, div_a_o, div_b_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Returns at the negedge one cycle after the accept edge.
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    @(negedge clk);
    chk("req_ready before accept", 32'(req_ready_o), 32'd1);
    req_valid_i  = 1'b1;
    req_funct3_i = f3;
    req_a_i      = a;
    req_b_i      = b;
    req_rd_i     = rd;
    @(negedge clk);
    req_valid_i  = 1'b0;
  endtask

  task automatic wait_resp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output int cyc, output int en_n, output bit ctl_bad);
    cyc = 1;
    en_n = 0;
    ctl_bad = 1'b0;
    while (resp_valid_o !== 1'b1 && cyc < 200) begin
      if (div_en_o === 1'b1) begin
        en_n++;
        if (div_a_o !== a || div_b_o !== b || div_funct3_o !== f3) ctl_bad = 1'b1;
      end
      if (alu_div_sel_o !== div_en_o || alu_sub_o !== (div_en_o & div_sub_i)) ctl_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int  cyc, en_n;
    bit  ctl_bad, bad;

    #400000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  cyc, en_n;
    bit  ctl_bad, bad;

    vecs[0]  = '{3'b101, 32'd100,        32'd7,          5'd5,  32'd14,         1'b0};
    vecs[1]  = '{3'b100, 32'hFFFF_FF9C,  32'd7,          5'd6,  32'hFFFF_FFF2,  1'b0};
    vecs[2]  = '{3'b110, 32'hFFFF_FF9C,  32'd7,          5'd7,  32'hFFFF_FFFE,  1'b0};
    vecs[3]  = '{3'b100, 32'h1234,       32'd0,          5'd8,  32'hFFFF_FFFF,  1'b1};
    vecs[4]  = '{3'b101, 32'h1234,       32'd0,          5'd9,  32'hFFFF_FFFF,  1'b1};
    vecs[5]  = '{3'b110, 32'h1234,       32'd0,          5'd10, 32'h1234,       1'b1};
    vecs[6]  = '{3'b111, 32'h1234,       32'd0,          5'd11, 32'h1234,       1'b1};
    vecs[7]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  1'b1};
    vecs[8]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h0,          1'b1};
    vecs[9]  = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'h0,          1'b0};
    vecs[10] = '{3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000,  1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {26'd0, resp_valid_o, div_en_o, alu_div_sel_o, alu_sub_o, busy_o, err_o},
        32'd0);
    chk("reset resp_data", resp_data_o, 32'd0);
    chk("reset resp_rd", 32'(resp_rd_o), 32'd0);
    chk("reset div_a", div_a_o, 32'd0);
    chk("reset div_b", div_b_o, 32'd0);
    chk("reset div_funct3", 32'(div_funct3_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("req_ready after reset", 32'(req_ready_o), 32'd1);

    // Directed vectors, writeback always ready
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
      wait_resp(vecs[i].f3, vecs[i].a, vecs[i].b, cyc, en_n, ctl_bad);
      chk($sformatf("v%0d latency", i), 32'(cyc), vecs[i].fast ? 32'd2 : 32'd68);
      chk($sformatf("v%0d div_en cycles", i), 32'(en_n), vecs[i].fast ? 32'd0 : 32'd67);
      chk($sformatf("v%0d operands/alu ctl", i), 32'(ctl_bad), 32'd0);
      chk($sformatf("v%0d resp_data", i), resp_data_o, vecs[i].exp);
      chk($sformatf("v%0d resp_rd", i), 32'(resp_rd_o), 32'(vecs[i].rd));
      @(negedge clk);
      chk($sformatf("v%0d idle after resp", i), {30'd0, busy_o, resp_valid_o}, 32'd0);
    end

    // Flush in RUN cycle 30
    send(3'b101, 32'd1000, 32'd10, 5'd3);
    for (int k = 1; k < 30; k++) @(negedge clk);
    chk("run before flush", 32'(div_en_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush in run", {28'd0, div_en_o, alu_div_sel_o, resp_valid_o, busy_o}, 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (resp_valid_o !== 1'b0 || div_en_o !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk("no resp after flush", 32'(bad), 32'd0);
    send(3'b101, 32'd9, 32'd3, 5'd17);
    wait_resp(3'b101, 32'd9, 32'd3, cyc, en_n, ctl_bad);
    chk("post-flush latency", 32'(cyc), 32'd68);
    chk("post-flush resp_data", resp_data_o, 32'd3);
    chk("post-flush resp_rd", 32'(resp_rd_o), 32'd17);

    // Flush beats a same-cycle request
    @(negedge clk);
    flush_i      = 1'b1;
    req_valid_i  = 1'b1;
    req_funct3_i = 3'b100;
    req_a_i      = 32'd1;
    req_b_i      = 32'd0;
    #1;
    chk("req_ready under flush", 32'(req_ready_o), 32'd0);
    @(negedge clk);
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    chk("no accept under flush", 32'(busy_o), 32'd0);

    // Flush beats a same-cycle resp handshake in DONE
    resp_ready_i = 1'b0;
    send(3'b100, 32'd5, 32'd0, 5'd20);
    wait_resp(3'b100, 32'd5, 32'd0, cyc, en_n, ctl_bad);
    chk("fast latency, writeback stalled", 32'(cyc), 32'd2);
    flush_i      = 1'b1;
    resp_ready_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush in done", {30'd0, resp_valid_o, busy_o}, 32'd0);
    chk("err after flush", 32'(err_o), 32'd0);

    // Watchdog: divider never finishes, writeback stalls
    finish_en    = 1'b0;
    resp_ready_i = 1'b0;
    send(3'b101, 32'd100, 32'd7, 5'd21);
    wait_resp(3'b101, 32'd100, 32'd7, cyc, en_n, ctl_bad);
    chk("timeout latency", 32'(cyc), 32'd81);
    chk("timeout run cycles", 32'(en_n), 32'd80);
    chk("timeout err", 32'(err_o), 32'd1);
    chk("timeout resp_data", resp_data_o, 32'd0);
    chk("timeout resp_rd", 32'(resp_rd_o), 32'd21);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (resp_valid_o !== 1'b1 || resp_data_o !== 32'd0 || resp_rd_o !== 5'd21 ||
          req_ready_o !== 1'b0 || err_o !== 1'b1) bad = 1'b1;
    end
    chk("resp held while stalled", 32'(bad), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset clears err", 32'(err_o), 32'd0);
    chk("reset clears resp", {29'd0, resp_valid_o, busy_o, div_en_o}, 32'd0);
    chk("reset clears data", resp_data_o, 32'd0);
    chk("reset clears operand", div_a_o, 32'd0);
    rst          = 1'b1;
    finish_en    = 1'b1;
    resp_ready_i = 1'b1;
    @(negedge clk);
    chk("req_ready after second reset", 32'(req_ready_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
